// File: rtl/debug_trace_spi.sv
// Multi-channel debug trace buffer: per-channel capture into a FIFO, streamed out
// as {valid, overflow, channel[5:0], data} records over an SPI mode-0 slave.
module debug_trace_spi #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0]        i_capture,
    input  logic                     i_freeze,
    input  logic                     i_spi_clk,
    input  logic                     i_csn,
    input  logic                     i_mosi,
    output logic                     o_miso,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic [DATA_W-1:0]        o_last_data
);
    localparam int RECORD_W = 8 + DATA_W;
    localparam int ENTRY_W  = 6 + DATA_W;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BC_W     = $clog2(RECORD_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} spi_state_t;

    // SPI pins are asynchronous: two flops to resolve metastability, a third for edge detect
    logic [2:0] sck_sr;
    logic [2:0] csn_sr;
    logic [1:0] mosi_sr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sr  <= '0;
            csn_sr  <= '1;
            mosi_sr <= '0;
        end else begin
            sck_sr  <= {sck_sr[1:0], i_spi_clk};
            csn_sr  <= {csn_sr[1:0], i_csn};
            mosi_sr <= {mosi_sr[0], i_mosi};
        end
    end

    logic sck_rise, sck_fall, csn_fall, csn_s, mosi_s;
    assign sck_rise = sck_sr[1] & ~sck_sr[2];
    assign sck_fall = ~sck_sr[1] & sck_sr[2];
    assign csn_fall = ~csn_sr[1] & csn_sr[2];
    assign csn_s    = csn_sr[1];
    assign mosi_s   = mosi_sr[1];

    logic [NUM_CH-1:0] pend_valid;
    logic [DATA_W-1:0] pend_data [NUM_CH];
    logic              overflow;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] last_data;
    logic              push, pop, clear_cmd;
    logic              sel_hit;
    logic [5:0]        sel_ch;
    logic [DATA_W-1:0] sel_data;

    // Lowest-index full pending register wins the single FIFO write port
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel_hit  = 1'b0;
        sel_ch   = '0;
        sel_data = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pend_valid[k]) begin
                sel_hit  = 1'b1;
                sel_ch   = 6'(k);
                sel_data = pend_data[k];
            end
        end
    end

    assign push = sel_hit && (count != CNT_W'(DEPTH)) && !clear_cmd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_valid <= '0;
            overflow   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) pend_data[k] <= '0;
        end else if (clear_cmd) begin
            pend_valid <= '0;
            overflow   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                // A channel draining this cycle frees its slot for a same-cycle strobe
                if (i_capture[k] && !i_freeze) begin
                    if (pend_valid[k] && !(push && sel_ch == 6'(k))) begin
                        overflow <= 1'b1;
                    end else begin
                        pend_valid[k] <= 1'b1;
                        pend_data[k]  <= i_data[k*DATA_W +: DATA_W];
                    end
                end else if (push && sel_ch == 6'(k)) begin
                    pend_valid[k] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count and the pointers alone.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {sel_ch, sel_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
        end else if (clear_cmd) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_data <= sel_data;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    spi_state_t          state, state_next;
    logic [RECORD_W-1:0] shift_reg, load_rec;
    logic [BC_W-1:0]     bit_cnt;
    logic [7:0]          cmd;
    logic                miso, rec_valid, rec_done, rec_end;

    assign load_rec = (count == '0) ? '0 : {1'b1, overflow, mem[rd_ptr]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        rec_end    = 1'b0;
        pop        = 1'b0;
        clear_cmd  = 1'b0;
        case (state)
            S_IDLE:  if (csn_fall) state_next = S_LOAD;
            S_LOAD:  state_next = S_SHIFT;
            S_SHIFT: if (sck_fall && rec_done) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
        if (state != S_IDLE && csn_s) state_next = S_IDLE;
        if (state == S_SHIFT && !csn_s && sck_rise && bit_cnt == BC_W'(RECORD_W - 1)) begin
            rec_end   = 1'b1;
            pop       = rec_valid && (count != '0);
            clear_cmd = (cmd == 8'hA5);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            cmd       <= '0;
            miso      <= 1'b0;
            rec_valid <= 1'b0;
            rec_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    miso     <= 1'b0;
                    bit_cnt  <= '0;
                    rec_done <= 1'b0;
                end
                S_LOAD: begin
                    shift_reg <= load_rec;
                    miso      <= load_rec[RECORD_W-1];
                    rec_valid <= (count != '0);
                    bit_cnt   <= '0;
                    rec_done  <= 1'b0;
                end
                S_SHIFT: begin
                    if (sck_rise) begin
                        if (bit_cnt < BC_W'(8)) cmd <= {cmd[6:0], mosi_s};
                        if (rec_end) begin
                            bit_cnt  <= '0;
                            rec_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    if (sck_fall && !rec_done) begin
                        shift_reg <= shift_reg << 1;
                        miso      <= shift_reg[RECORD_W-2];
                    end
                end
                default: miso <= 1'b0;
            endcase
        end
    end

    assign o_miso      = miso;
    assign o_count     = count;
    assign o_overflow  = overflow;
    assign o_last_data = last_data;
endmodule
